ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

Pipeline register and operand-forwarding stage feeding the 16-bit execute ALU. It latches decoded operands and ALU controls from decode, keeps held operands current while stalled, and drives the ALU's A, B, cin, op, invA, invB and sign inputs. It also resolves read-after-write hazards against results from the memory and writeback stages. It supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
Parameters:
- none; the datapath is fixed at 16 bits and register specifiers are fixed at 3 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  the decode stage presents a real instruction.
- stall  in  1  hold the current contents; decode keeps its outputs stable.
- flush  in  1  replace the contents with a bubble.
- id_A, id_B  in  16 each  operand values read from the register file.
- id_rs, id_rt  in  3 each  source register specifiers for A and B.
- id_useRs, id_useRt  in  1 each  the operand comes from a register; when 0, forwarding is disabled for that operand (immediate).
- id_op  in  3  ALU op.
- id_cin, id_invA, id_invB, id_sign  in  1 each  ALU controls.
- id_wreg  in  3  destination register.
- id_wen  in  1  the instruction writes a register.
- mem_wen, mem_wreg, mem_data  in  1/3/16  result of the instruction currently in the memory stage.
- wb_wen, wb_wreg, wb_data  in  1/3/16  result being written back this cycle.
- ex_valid  out  1  the stage holds a real instruction.
- A, B  out  16 each  forwarded ALU operands.
- cin, op, invA, invB, sign  out  1/3/1/1/1  registered ALU controls.
- ex_wreg, ex_wen  out  3/1  registered destination; ex_wen is gated by ex_valid.
- fwdA, fwdB  out  2 each  forward source of each operand: 0 = held value, 1 = WB, 2 = MEM.

## Operation
- State held per operand: value (16 bits), reg (3 bits), use (1 bit). State also includes the control fields, wreg, wen and valid.
- Update priority on each edge: rst, then flush, then stall, then load.
  - rst: clear every register to 0.
  - flush: set valid=0 and wen=0. Other fields are don't-care but are cleared to 0.
  - stall, not flush: hold all fields, but refresh the held value. If valid && use && wb_wen && wb_wreg==reg, the held value takes wb_data. This ensures a writeback that retires during a stall is not lost.
  - load, neither rst/flush nor stall: capture all id_* fields. valid takes id_valid. wen takes id_wen && id_valid.
    - Register-file bypass at capture: if id_use && wb_wen && wb_wreg==id_reg, the captured value is wb_data instead of id_A or id_B.
- Output operand selection is combinational from the held state:
  - MEM match: use && mem_wen && mem_wreg==reg gives mem_data, fwd=2.
  - otherwise, WB match: use && wb_wen && wb_wreg==reg gives wb_data, fwd=1.
  - otherwise the held value, fwd=0.
  - MEM has priority over WB, because it is the younger producer.
- All outputs except A, B, fwdA and fwdB come directly from registers.
- With ex_valid=0, fwdA and fwdB are forced to 0 and ex_wen is 0. A and B still follow the selection rules; they are don't-care downstream.
- Register 0 is a general register and has no special case.
- The stage does not detect load-use hazards. The hazard unit asserts stall, and a load's mem_data is valid only when the memory stage flags it.

## Timing
- Latency: decode values appear on the ALU inputs one cycle after the load edge.
- Forwarding paths are combinational in the execute cycle, with no added latency.
- Reset values: ex_valid=0, ex_wen=0, ex_wreg=0, op=0, cin/invA/invB/sign=0, fwdA=fwdB=0. A and B equal the held value 0 unless a MEM/WB match exists; none can exist, since use=0 after reset.
- Simultaneous events:
  - stall and flush: flush wins and a bubble is inserted.
  - rst with anything: reset wins.
  - stall held N cycles: contents stable, apart from WB refreshes of held values.
- Reset mid-operation: the instruction in the stage is discarded, and the next cycle shows a bubble.
- Back-to-back loads with no stall: one instruction per cycle, no bubbles introduced.

## Test plan
- Reset then load: load id_A=0x1234, id_B=0x00FF, op=3, use=0. On the next cycle A=0x1234, B=0x00FF, op=3, ex_valid=1, fwdA=fwdB=0.
- MEM forward: held rs=2, use=1, with mem_wen=1, mem_wreg=2, mem_data=0xBEEF. Expect A=0xBEEF, fwdA=2. Also drive wb_wreg=2, wb_data=0x1111: MEM still wins.
- Capture bypass: id_rt=5 with id_B=0x0000, and wb_wen=1, wb_wreg=5, wb_data=0x7777 on the load edge. Next cycle B=0x7777 with fwdB=0, since WB has since deasserted.
- Stall refresh: hold 3 cycles. In cycle 2, WB writes rs=4 with 0xA5A5 while the held rs=4. After the stall is released, with no forwards present, A=0xA5A5.
- Flush vs stall: stall=1 and flush=1 together with a valid instruction held. Next cycle ex_valid=0, ex_wen=0, fwdA=fwdB=0.
- Immediate operand: use=0, rs field=3, mem_wreg=3, mem_wen=1. A equals the held value and fwdA=0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: latches decoded operands and ALU controls,
// resolves RAW hazards against MEM/WB results and supports stall and flush.
module ex_operand_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] id_A,
    input  logic [15:0] id_B,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_useRs,
    input  logic        id_useRt,
    input  logic [2:0]  id_op,
    input  logic        id_cin,
    input  logic        id_invA,
    input  logic        id_invB,
    input  logic        id_sign,
    input  logic [2:0]  id_wreg,
    input  logic        id_wen,
    input  logic        mem_wen,
    input  logic [2:0]  mem_wreg,
    input  logic [15:0] mem_data,
    input  logic        wb_wen,
    input  logic [2:0]  wb_wreg,
    input  logic [15:0] wb_data,
    output logic        ex_valid,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        cin,
    output logic [2:0]  op,
    output logic        invA,
    output logic        invB,
    output logic        sign,
    output logic [2:0]  ex_wreg,
    output logic        ex_wen,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB
);

    logic        r_valid;
    logic [15:0] r_a_val;
    logic [2:0]  r_a_reg;
    logic        r_a_use;
    logic [15:0] r_b_val;
    logic [2:0]  r_b_reg;
    logic        r_b_use;
    logic [2:0]  r_op;
    logic        r_cin;
    logic        r_inva;
    logic        r_invb;
    logic        r_sign;
    logic [2:0]  r_wreg;
    logic        r_wen;

    logic [15:0] w_id_a;
    logic [15:0] w_id_b;
    logic        w_a_mem;
    logic        w_a_wb;
    logic        w_b_mem;
    logic        w_b_wb;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    // Register-file bypass at capture: a writeback retiring on the load edge
    // is newer than the value decode read from the register file.
    always_comb begin
        w_id_a = id_A;
        w_id_b = id_B;
        if (id_useRs && wb_wen && (wb_wreg == id_rs)) begin
            w_id_a = wb_data;
        end else begin
            w_id_a = id_A;
        end
        if (id_useRt && wb_wen && (wb_wreg == id_rt)) begin
            w_id_b = wb_data;
        end else begin
            w_id_b = id_B;
        end
    end

    // Stage register: reset, then flush, then stall (with WB refresh), then load.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= 1'b0;
            r_a_val <= 16'h0000;
            r_a_reg <= 3'd0;
            r_a_use <= 1'b0;
            r_b_val <= 16'h0000;
            r_b_reg <= 3'd0;
            r_b_use <= 1'b0;
            r_op    <= 3'd0;
            r_cin   <= 1'b0;
            r_inva  <= 1'b0;
            r_invb  <= 1'b0;
            r_sign  <= 1'b0;
            r_wreg  <= 3'd0;
            r_wen   <= 1'b0;
        end else if (stall) begin
            if (r_valid && r_a_use && wb_wen && (wb_wreg == r_a_reg)) begin
                r_a_val <= wb_data;
            end
            if (r_valid && r_b_use && wb_wen && (wb_wreg == r_b_reg)) begin
                r_b_val <= wb_data;
            end
        end else begin
            r_valid <= id_valid;
            r_a_val <= w_id_a;
            r_a_reg <= id_rs;
            r_a_use <= id_useRs;
            r_b_val <= w_id_b;
            r_b_reg <= id_rt;
            r_b_use <= id_useRt;
            r_op    <= id_op;
            r_cin   <= id_cin;
            r_inva  <= id_invA;
            r_invb  <= id_invB;
            r_sign  <= id_sign;
            r_wreg  <= id_wreg;
            r_wen   <= id_wen && id_valid;
        end
    end

    // Operand forwarding: MEM is the younger producer, so it beats WB.
    always_comb begin
        w_a_mem = r_a_use && mem_wen && (mem_wreg == r_a_reg);
        w_a_wb  = r_a_use && wb_wen  && (wb_wreg  == r_a_reg);
        w_b_mem = r_b_use && mem_wen && (mem_wreg == r_b_reg);
        w_b_wb  = r_b_use && wb_wen  && (wb_wreg  == r_b_reg);
        if (w_a_mem) begin
            A       = mem_data;
            w_fwd_a = 2'd2;
        end else if (w_a_wb) begin
            A       = wb_data;
            w_fwd_a = 2'd1;
        end else begin
            A       = r_a_val;
            w_fwd_a = 2'd0;
        end
        if (w_b_mem) begin
            B       = mem_data;
            w_fwd_b = 2'd2;
        end else if (w_b_wb) begin
            B       = wb_data;
            w_fwd_b = 2'd1;
        end else begin
            B       = r_b_val;
            w_fwd_b = 2'd0;
        end
        if (r_valid) begin
            fwdA = w_fwd_a;
            fwdB = w_fwd_b;
        end else begin
            fwdA = 2'd0;
            fwdB = 2'd0;
        end
    end

    assign ex_valid = r_valid;
    assign op       = r_op;
    assign cin      = r_cin;
    assign invA     = r_inva;
    assign invB     = r_invb;
    assign sign     = r_sign;
    assign ex_wreg  = r_wreg;
    assign ex_wen   = r_wen;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: expected ALU-input snapshots are queued
// as stimulus is driven and compared with immediate assertions.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst, id_valid, stall, flush;
    logic [15:0] id_A, id_B;
    logic [2:0]  id_rs, id_rt;
    logic        id_useRs, id_useRt;
    logic [2:0]  id_op;
    logic        id_cin, id_invA, id_invB, id_sign;
    logic [2:0]  id_wreg;
    logic        id_wen;
    logic        mem_wen;
    logic [2:0]  mem_wreg;
    logic [15:0] mem_data;
    logic        wb_wen;
    logic [2:0]  wb_wreg;
    logic [15:0] wb_data;
    logic        ex_valid;
    logic [15:0] A, B;
    logic        cin;
    logic [2:0]  op;
    logic        invA, invB, sign;
    logic [2:0]  ex_wreg;
    logic        ex_wen;
    logic [1:0]  fwdA, fwdB;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [2:0]  op;
        logic [3:0]  ctl;
        logic        valid;
        logic [2:0]  wreg;
        logic        wen;
    } snap_t;

    snap_t sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .stall(stall), .flush(flush),
        .id_A(id_A), .id_B(id_B), .id_rs(id_rs), .id_rt(id_rt),
        .id_useRs(id_useRs), .id_useRt(id_useRt), .id_op(id_op),
        .id_cin(id_cin), .id_invA(id_invA), .id_invB(id_invB), .id_sign(id_sign),
        .id_wreg(id_wreg), .id_wen(id_wen),
        .mem_wen(mem_wen), .mem_wreg(mem_wreg), .mem_data(mem_data),
        .wb_wen(wb_wen), .wb_wreg(wb_wreg), .wb_data(wb_data),
        .ex_valid(ex_valid), .A(A), .B(B), .cin(cin), .op(op),
        .invA(invA), .invB(invB), .sign(sign), .ex_wreg(ex_wreg), .ex_wen(ex_wen),
        .fwdA(fwdA), .fwdB(fwdB)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic snap_t mk(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [2:0] o, input logic [3:0] ctl,
                                 input logic v, input logic [2:0] wr, input logic we);
        snap_t s;
        s.a = a; s.b = b; s.fa = fa; s.fb = fb; s.op = o; s.ctl = ctl;
        s.valid = v; s.wreg = wr; s.wen = we;
        return s;
    endfunction

    task automatic push(input snap_t s);
        sb_q.push_back(s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag);
        snap_t obs;
        snap_t exp_s;
        obs = mk(A, B, fwdA, fwdB, op, {cin, invA, invB, sign}, ex_valid, ex_wreg, ex_wen);
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, observed=%h required=queued entry", tag, obs);
        end else begin
            exp_s = sb_q.pop_front();
            assert (obs === exp_s) else begin
                n_err++;
                $error("FAIL %s: observed=%h expected=%h (A B fA fB op ctl v wreg wen)", tag, obs, exp_s);
            end
        end
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        id_A = 16'h0000; id_B = 16'h0000; id_rs = 3'd0; id_rt = 3'd0;
        id_useRs = 1'b0; id_useRt = 1'b0; id_op = 3'd0;
        id_cin = 1'b0; id_invA = 1'b0; id_invB = 1'b0; id_sign = 1'b0;
        id_wreg = 3'd0; id_wen = 1'b0;
        mem_wen = 1'b0; mem_wreg = 3'd0; mem_data = 16'h0000;
        wb_wen = 1'b0; wb_wreg = 3'd0; wb_data = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        push(mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd0, 4'b0000, 1'b0, 3'd0, 1'b0));
        check("reset");

        // plain load, immediates
        id_valid = 1'b1; id_A = 16'h1234; id_B = 16'h00FF; id_op = 3'd3;
        id_cin = 1'b1; id_sign = 1'b1; id_wreg = 3'd1; id_wen = 1'b1;
        push(mk(16'h1234, 16'h00FF, 2'd0, 2'd0, 3'd3, 4'b1001, 1'b1, 3'd1, 1'b1));
        tick();
        check("load");

        // MEM over WB, then WB alone, then stall refresh from WB
        id_rs = 3'd2; id_useRs = 1'b1; id_A = 16'h0002;
        id_rt = 3'd6; id_useRt = 1'b1; id_B = 16'h0B0B;
        id_op = 3'd5; id_cin = 1'b0; id_sign = 1'b0; id_invA = 1'b1;
        id_wreg = 3'd2; id_wen = 1'b0;
        tick();
        stall = 1'b1;
        mem_wen = 1'b1; mem_wreg = 3'd2; mem_data = 16'hBEEF;
        wb_wen = 1'b1; wb_wreg = 3'd2; wb_data = 16'h1111;
        push(mk(16'hBEEF, 16'h0B0B, 2'd2, 2'd0, 3'd5, 4'b0100, 1'b1, 3'd2, 1'b0));
        #1;
        check("mem_fwd_over_wb");
        mem_wen = 1'b0;
        push(mk(16'h1111, 16'h0B0B, 2'd1, 2'd0, 3'd5, 4'b0100, 1'b1, 3'd2, 1'b0));
        #1;
        check("wb_fwd");
        tick();
        wb_wen = 1'b0;
        push(mk(16'h1111, 16'h0B0B, 2'd0, 2'd0, 3'd5, 4'b0100, 1'b1, 3'd2, 1'b0));
        #1;
        check("stall_refresh_hold");

        // capture bypass on B, immediate A ignores MEM match
        stall = 1'b0;
        id_rs = 3'd3; id_useRs = 1'b0; id_A = 16'hAAAA;
        id_rt = 3'd5; id_useRt = 1'b1; id_B = 16'h0000;
        wb_wen = 1'b1; wb_wreg = 3'd5; wb_data = 16'h7777;
        id_op = 3'd1; id_invA = 1'b0; id_invB = 1'b1; id_wreg = 3'd5; id_wen = 1'b1;
        push(mk(16'hAAAA, 16'h7777, 2'd0, 2'd0, 3'd1, 4'b0010, 1'b1, 3'd5, 1'b1));
        tick();
        wb_wen = 1'b0;
        #1;
        check("capture_bypass");
        mem_wen = 1'b1; mem_wreg = 3'd3; mem_data = 16'hDEAD;
        push(mk(16'hAAAA, 16'h7777, 2'd0, 2'd0, 3'd1, 4'b0010, 1'b1, 3'd5, 1'b1));
        #1;
        check("imm_no_fwd");

        // three-cycle stall with a WB to the held rs in the middle
        mem_wen = 1'b0;
        id_rs = 3'd4; id_useRs = 1'b1; id_A = 16'h0004;
        id_rt = 3'd0; id_useRt = 1'b1; id_B = 16'h5555;
        id_op = 3'd2; id_invB = 1'b0; id_wreg = 3'd7; id_wen = 1'b1;
        push(mk(16'h0004, 16'h5555, 2'd0, 2'd0, 3'd2, 4'b0000, 1'b1, 3'd7, 1'b1));
        tick();
        check("load_rs4");
        stall = 1'b1; id_A = 16'h9999; id_valid = 1'b0;
        push(mk(16'h0004, 16'h5555, 2'd0, 2'd0, 3'd2, 4'b0000, 1'b1, 3'd7, 1'b1));
        tick();
        check("stall_c1_hold");
        wb_wen = 1'b1; wb_wreg = 3'd4; wb_data = 16'hA5A5;
        push(mk(16'hA5A5, 16'h5555, 2'd1, 2'd0, 3'd2, 4'b0000, 1'b1, 3'd7, 1'b1));
        #1;
        check("stall_c2_wb_fwd");
        tick();
        wb_wen = 1'b0;
        push(mk(16'hA5A5, 16'h5555, 2'd0, 2'd0, 3'd2, 4'b0000, 1'b1, 3'd7, 1'b1));
        #1;
        check("stall_c2_refresh");
        tick();
        stall = 1'b0;
        push(mk(16'hA5A5, 16'h5555, 2'd0, 2'd0, 3'd2, 4'b0000, 1'b1, 3'd7, 1'b1));
        check("stall_release");
        mem_wen = 1'b1; mem_wreg = 3'd0; mem_data = 16'h0F0F;
        push(mk(16'hA5A5, 16'h0F0F, 2'd0, 2'd2, 3'd2, 4'b0000, 1'b1, 3'd7, 1'b1));
        #1;
        check("reg0_mem_fwd");
        mem_wen = 1'b0;

        // flush beats stall
        stall = 1'b1; flush = 1'b1;
        push(mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd0, 4'b0000, 1'b0, 3'd0, 1'b0));
        tick();
        stall = 1'b0; flush = 1'b0;
        check("flush_over_stall");

        // back-to-back loads including a non-valid one
        id_valid = 1'b1; id_A = 16'h1001; id_B = 16'h2002; id_useRs = 1'b0; id_useRt = 1'b0;
        id_op = 3'd4; id_cin = 1'b1; id_invA = 1'b1; id_invB = 1'b1; id_sign = 1'b1;
        id_wreg = 3'd3; id_wen = 1'b1;
        push(mk(16'h1001, 16'h2002, 2'd0, 2'd0, 3'd4, 4'b1111, 1'b1, 3'd3, 1'b1));
        tick();
        check("b2b_1");
        id_valid = 1'b0; id_rs = 3'd1; id_useRs = 1'b1; id_A = 16'h3003; id_B = 16'h4004;
        id_op = 3'd6; id_cin = 1'b0; id_invA = 1'b0; id_invB = 1'b0; id_sign = 1'b0;
        id_wreg = 3'd4; id_wen = 1'b1;
        tick();
        mem_wen = 1'b1; mem_wreg = 3'd1; mem_data = 16'hCAFE;
        push(mk(16'hCAFE, 16'h4004, 2'd0, 2'd0, 3'd6, 4'b0000, 1'b0, 3'd4, 1'b0));
        #1;
        check("invalid_fwd_flag_zero");
        mem_wen = 1'b0;
        id_valid = 1'b1; id_useRs = 1'b0; id_A = 16'h5005; id_B = 16'h6006;
        id_op = 3'd7; id_wreg = 3'd6; id_wen = 1'b1;
        push(mk(16'h5005, 16'h6006, 2'd0, 2'd0, 3'd7, 4'b0000, 1'b1, 3'd6, 1'b1));
        tick();
        check("b2b_3");

        // reset mid-operation, then normal reload
        rst = 1'b1;
        push(mk(16'h0000, 16'h0000, 2'd0, 2'd0, 3'd0, 4'b0000, 1'b0, 3'd0, 1'b0));
        tick();
        rst = 1'b0;
        check("reset_mid_op");
        push(mk(16'h5005, 16'h6006, 2'd0, 2'd0, 3'd7, 4'b0000, 1'b1, 3'd6, 1'b1));
        tick();
        check("post_reset_load");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
